// File: rtl/junction_phase_scheduler_if.sv
// Request inputs and light/status outputs of the junction phase scheduler.
// The master side drives requests; the scheduler is the slave.
interface junction_phase_scheduler_if;
   logic       tick;
   logic       country_req;
   logic       ped_req;
   logic       emerg;
   logic [2:0] highway_lights;
   logic [2:0] country_lights;
   logic       ped_walk;
   logic       ped_wait;
   logic [2:0] phase;

   modport master (
      output tick, country_req, ped_req, emerg,
      input  highway_lights, country_lights, ped_walk, ped_wait, phase
   );

   modport slave (
      input  tick, country_req, ped_req, emerg,
      output highway_lights, country_lights, ped_walk, ped_wait, phase
   );
endinterface

// File: rtl/junction_phase_scheduler.sv
// Demand-driven highway/country-road junction scheduler with pedestrian
// walk phase and emergency pre-empt back to highway green.
module junction_phase_scheduler #(
   parameter int unsigned MIN_GREEN        = 8,
   parameter int unsigned MAX_GREEN        = 16,
   parameter int unsigned YELLOW_DURATION  = 3,
   parameter int unsigned ALL_RED_DURATION = 1,
   parameter int unsigned WALK_DURATION    = 6
) (
   input logic clk,
   input logic reset,
   junction_phase_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      CG  = 3'd3,
      CY  = 3'd4,
      AR2 = 3'd5,
      PW  = 3'd6,
      ILL = 3'd7
   } state_e;

   typedef enum logic {
      GR_CTRY = 1'b0,
      GR_PED  = 1'b1
   } req_e;

   localparam logic [7:0] MIN_M1  = 8'(MIN_GREEN - 1);
   localparam logic [7:0] MAX_M1  = 8'(MAX_GREEN - 1);
   localparam logic [7:0] YEL_M1  = 8'(YELLOW_DURATION - 1);
   localparam logic [7:0] AR_M1   = 8'(ALL_RED_DURATION - 1);
   localparam logic [7:0] WALK_M1 = 8'(WALK_DURATION - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       ctry_pend_q, ctry_pend_d;
   logic       ped_pend_q, ped_pend_d;
   req_e       grant_q, grant_d;
   req_e       last_q, last_d;

   logic min_done, max_done, yel_done, ar_done, walk_done;

   assign min_done  = bus.tick && (cnt_q >= MIN_M1);
   assign max_done  = bus.tick && (cnt_q == MAX_M1);
   assign yel_done  = bus.tick && (cnt_q == YEL_M1);
   assign ar_done   = bus.tick && (cnt_q == AR_M1);
   assign walk_done = bus.tick && (cnt_q == WALK_M1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      unique case (state_q)
         HG: begin
            if (min_done && (ctry_pend_q || ped_pend_q) && !bus.emerg) begin
               state_d = HY;
               // Alternate when both wait so neither starves
               if (ctry_pend_q && ped_pend_q)
                  grant_d = (last_q == GR_CTRY) ? GR_PED : GR_CTRY;
               else if (ctry_pend_q)
                  grant_d = GR_CTRY;
               else
                  grant_d = GR_PED;
            end
         end
         HY: if (yel_done) state_d = AR1;
         AR1: begin
            if (ar_done) begin
               if (bus.emerg) begin
                  state_d = HG;
               end else if (grant_q == GR_CTRY) begin
                  state_d = CG;
                  last_d  = GR_CTRY;
               end else begin
                  state_d = PW;
                  last_d  = GR_PED;
               end
            end
         end
         CG: begin
            if (bus.emerg || (min_done && !bus.country_req) || max_done)
               state_d = CY;
         end
         CY:  if (yel_done) state_d = AR2;
         PW:  if (bus.emerg || walk_done) state_d = AR2;
         AR2: if (ar_done) state_d = HG;
         ILL: state_d = HG;
         default: state_d = HG;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (bus.tick && (cnt_q != 8'hFF))
         cnt_d = cnt_q + 8'd1;
   end

   // Clearing on the entry edge wins over a request in the same cycle
   assign ctry_pend_d = (state_d == CG && state_q != CG) ? 1'b0
                      : (ctry_pend_q | bus.country_req);
   assign ped_pend_d  = (state_d == PW && state_q != PW) ? 1'b0
                      : (ped_pend_q | bus.ped_req);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= HG;
         cnt_q       <= '0;
         ctry_pend_q <= 1'b0;
         ped_pend_q  <= 1'b0;
         grant_q     <= GR_CTRY;
         last_q      <= GR_PED;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ctry_pend_q <= ctry_pend_d;
         ped_pend_q  <= ped_pend_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
      end
   end

   always_comb begin
      bus.highway_lights = 3'b100;
      bus.country_lights = 3'b100;
      bus.ped_walk       = 1'b0;
      bus.phase          = state_q;
      unique case (state_q)
         HG:  bus.highway_lights = 3'b001;
         HY:  bus.highway_lights = 3'b010;
         CG:  bus.country_lights = 3'b001;
         CY:  bus.country_lights = 3'b010;
         PW:  bus.ped_walk       = 1'b1;
         ILL: begin
            bus.highway_lights = 3'b001;
            bus.phase          = HG;
         end
         default: ;
      endcase
   end

   assign bus.ped_wait = ped_pend_q;

endmodule

// File: doc/junction_phase_scheduler.md
Name: junction_phase_scheduler

Overview:
- Demand-driven phase scheduler for the highway/country-road junction.
- Shares the junction between three requesters: the country-road vehicle sensor, the pedestrian push-button and the emergency pre-empt input.
- The highway holds green by default and yields only when a request is pending.
- Drives the same 3-bit light encoding as the fixed-cycle controller (001 green, 010 yellow, 100 red), plus pedestrian walk/wait indicators.

Parameters:
- MIN_GREEN, 8: minimum green time, in ticks, for both highway and country road.
- MAX_GREEN, 16: maximum country green time, in ticks.
- YELLOW_DURATION, 3: yellow time, in ticks.
- ALL_RED_DURATION, 1: all-red clearance time, in ticks.
- WALK_DURATION, 6: pedestrian walk time, in ticks.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- tick  input  1  single-cycle timing strobe; the time base for all durations.
- country_req  input  1  level; vehicle present on the country road.
- ped_req  input  1  pedestrian button; a pulse of any length.
- emerg  input  1  level; emergency pre-empt, forces highway green.
- highway_lights  output  3  highway light encoding.
- country_lights  output  3  country-road light encoding.
- ped_walk  output  1  walk signal.
- ped_wait  output  1  pedestrian request latched and not yet served.
- phase  output  3  current state code, for debug and status.

Behaviour:
- States and phase codes:
  - HG=0: highway 001, country 100.
  - HY=1: highway 010, country 100.
  - AR1=2: 100/100.
  - CG=3: highway 100, country 001.
  - CY=4: highway 100, country 010.
  - AR2=5: 100/100.
  - PW=6: 100/100, ped_walk=1.
  - Code 7 is illegal: decodes as HG and transitions to HG on the next edge.
- Outputs are a combinational decode of the state register, except ped_wait = ped_pend register.
- Reset while asserted:
  - state=HG, cnt=0, ctry_pend=0, ped_pend=0, grant=0, last_served=PED.
  - Outputs: highway 001, country 100, ped_walk 0, ped_wait 0, phase 0.
  - Takes effect immediately, mid-phase included; no clearance is inserted.
- Counter cnt, 8 bits:
  - Increments on tick; cleared to 0 on every state change.
  - "D elapsed" means tick=1 and cnt==D-1 in that cycle; the transition occurs on that edge.
- Pending latches, sampled every cycle:
  - country_req=1 sets ctry_pend; ped_req=1 sets ped_pend.
  - ctry_pend is cleared on the edge entering CG; ped_pend is cleared on the edge entering PW.
  - Clear has priority on the entry edge. A request present in any later cycle re-latches.
- HG:
  - Exits to HY when all of the following hold: tick=1, cnt>=MIN_GREEN-1, (ctry_pend or ped_pend), emerg=0.
  - On that edge grant is chosen:
    - Only one pending: that requester.
    - Both pending: the one not equal to last_served.
  - With no requests HG holds indefinitely. The counter saturates at 255 and does not wrap.
- HY: YELLOW_DURATION elapsed -> AR1.
- AR1: ALL_RED_DURATION elapsed, then:
  - emerg=1 -> HG; the pending latch is retained.
  - Otherwise grant=COUNTRY -> CG, grant=PED -> PW.
  - last_served is updated on entry to CG or PW.
- CG exits to CY on the first of:
  - emerg=1: next edge, tick not required.
  - tick with cnt>=MIN_GREEN-1 and country_req=0 (gap-out).
  - MAX_GREEN elapsed (max-out).
- CY: YELLOW_DURATION elapsed -> AR2.
- PW:
  - WALK_DURATION elapsed -> AR2.
  - emerg=1 -> AR2 on the next edge.
- AR2: ALL_RED_DURATION elapsed -> HG.
- Safety invariant: highway and country are never both non-red; ped_walk=1 only in PW.
- Simultaneous events:
  - emerg overrides gap-out and max-out.
  - tick is ignored for the emergency exits.
  - A duration of 1 means exactly one tick in the state.

Test Plan:
- Reset release, no requests, tick every cycle for 300 cycles -> phase stays 0, highway 001, country 100, cnt saturated at 255.
- country_req held 1 from reset release -> HG 8 ticks, HY 3, AR1 1, CG max-out at 16, CY 3, AR2 1, HG; ctry_pend re-latched, so HY follows again after 8 ticks.
- ped_req 1-cycle pulse at cycle 2 -> ped_wait=1 until PW entry; after HG(8)/HY(3)/AR1(1), ped_walk=1 for 6 ticks with both lights 100; AR2 1; then HG.
- country_req and ped_req both asserted at cycle 0 (country_req dropped after 2 cycles) -> CG served first and gaps out at MIN_GREEN; next HG cycle serves PW; third round with both pending again selects country.
- emerg=1 at CG tick 3 -> CY on next edge; after CY 3 and AR2 1, HG holds while emerg=1, even with ped_pend=1; emerg drop -> normal arbitration resumes.
- reset driven 0 mid-CY (cnt=1), asynchronously between clock edges -> highway 001, country 100, phase 0 immediately; both pending latches read 0 after release.
